// File: rtl/counter_step_scheduler.sv
// counter_step_scheduler
//   Shares one up/down counter between two requesters. Each requester asks
//   for a move of N steps in a chosen direction. A round-robin arbiter grants
//   one request at a time, and the granted move drives the counter's
//   enable/up_down pins through a programmable step-rate prescaler.
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   req0/req1      requests, held high until the matching ack
//   dir0/dir1      move direction (1 = up, 0 = down)
//   steps0/steps1  number of steps in the move
//   ack0/ack1      one-cycle grant pulses
//   div            cycles between steps minus 1 (0 = one step per cycle)
//   cnt_en         counter enable, one-cycle pulse per step
//   cnt_up         counter up_down
//   busy           a move (or its completion cycle) is in progress
//   owner          id of the requester last granted
//   done           one-cycle pulse when a granted move completes
//
// All outputs are registered. Timing relative to the grant edge G:
//   ack at G, first cnt_en at G+div+1, later pulses every div+1 cycles,
//   done one cycle after the last pulse (or one cycle after ack when the
//   move has zero steps).
module counter_step_scheduler #(
    parameter int STEP_W = 4,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              dir0,
    input  logic [STEP_W-1:0] steps0,
    output logic              ack0,
    input  logic              req1,
    input  logic              dir1,
    input  logic [STEP_W-1:0] steps1,
    output logic              ack1,
    input  logic [DIV_W-1:0]  div,
    output logic              cnt_en,
    output logic              cnt_up,
    output logic              busy,
    output logic              owner,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [STEP_W-1:0]  remaining;
    logic [DIV_W-1:0]   prescaler;
    logic [DIV_W-1:0]   div_lat;
    logic               last_grant;

    logic               grant_any;
    logic               grant_id;
    logic               sel_dir;
    logic [STEP_W-1:0]  sel_steps;

    // Arbitration: a lone request wins outright; on a tie the requester
    // that was not granted last time wins.
    always_comb begin
        grant_any = req0 | req1;
        if (req0 && req1) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1;
        end
        sel_dir   = grant_id ? dir1 : dir0;
        sel_steps = grant_id ? steps1 : steps0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            remaining  <= '0;
            prescaler  <= '0;
            div_lat    <= '0;
            last_grant <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            cnt_en     <= 1'b0;
            cnt_up     <= 1'b0;
            busy       <= 1'b0;
            owner      <= 1'b0;
            done       <= 1'b0;
        end else begin
            // Pulse outputs default low each cycle.
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            cnt_en <= 1'b0;
            done   <= 1'b0;

            case (state)
                IDLE: begin
                    cnt_up <= 1'b0;
                    busy   <= 1'b0;
                    if (grant_any) begin
                        ack0       <= ~grant_id;
                        ack1       <= grant_id;
                        owner      <= grant_id;
                        last_grant <= grant_id;
                        busy       <= 1'b1;
                        prescaler  <= '0;
                        div_lat    <= div;
                        remaining  <= sel_steps;
                        if (sel_steps != '0) begin
                            cnt_up <= sel_dir;
                            state  <= RUN;
                        end else begin
                            state  <= DONE;
                        end
                    end
                end

                RUN: begin
                    if (prescaler == div_lat) begin
                        cnt_en    <= 1'b1;
                        prescaler <= '0;
                        remaining <= remaining - 1'b1;
                        // This pulse is the last one; completion follows.
                        if (remaining == STEP_W'(1)) begin
                            state <= DONE;
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end

                DONE: begin
                    // cnt_up was held through the final pulse; release it now.
                    done   <= 1'b1;
                    cnt_up <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
